alu_lock_arbiter: RTL and testbench
===================================

Name: alu_lock_arbiter

Overview:
Arbitrates the shared ALU among NUM_SIC SIC execution units. Each unit raises a lock request tagged with its issue_id. The arbiter grants the lock to the oldest requester (wrap-aware issue_id order) and holds it until that unit releases it or abandons the request. It muxes the owner's alu_req_t onto the single ALU port; the ALU answer goes back to the units through a plain broadcast wire, not through this block.

Parameters:
NUM_SIC, 4, number of requesting SIC units (>=2)
ID_WIDTH, 8, issue_id width; live issue_ids span less than 2^(ID_WIDTH-1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_SIC  per-SIC lock request (level)
req_issue_id  input  NUM_SIC*ID_WIDTH  per-SIC issue_id; slice i is bits [i*ID_WIDTH +: ID_WIDTH]
release_lock  input  NUM_SIC  per-SIC single-cycle release pulse
sic_alu_req  input  NUM_SIC x alu_req_t  per-SIC ALU operation (packed array)
grant  output  NUM_SIC  one-hot lock grant (registered)
alu_req  output  alu_req_t  operation driven to the ALU
owner_valid  output  1  lock is currently held
owner_idx  output  $clog2(NUM_SIC)  index of the current owner
grant_count  output  32  number of grants issued, wraps at 2^32

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant=0, owner_valid=0, owner_idx=0, grant_count=0. alu_req=0 while owner_valid=0.
- FSM states: IDLE, BUSY.
- IDLE: if any req[i]=1, pick winner w combinationally. At the next edge: grant[w]=1, owner_idx=w, owner_valid=1, grant_count+=1, state=BUSY. Grant latency is 1 cycle from the first sampled req.
- Winner selection: among req=1, choose the oldest issue_id. a is older than b iff (a-b) mod 2^ID_WIDTH has MSB=1. Equal ids: lowest index wins.
- BUSY: grant stays stable.
  - Leave BUSY at the next edge if release_lock[owner_idx]=1 OR req[owner_idx]=0 (abort/abandon).
  - On leaving: grant=0, owner_valid=0, state=IDLE.
  - owner_idx keeps its last value.
- No back-to-back grant: at least one IDLE cycle with grant=0 between owners. The same SIC may win again after that bubble.
- Simultaneous release_lock and req from the owner: the release wins. The SIC re-arbitrates in the following IDLE cycle.
- release_lock from a non-owner, or any release_lock in IDLE: ignored, no state change.
- New requesters arriving during BUSY: no preemption, even if they are older. They are considered at the next IDLE.
- alu_req = sic_alu_req[owner_idx] when owner_valid=1, else all zero. This path is combinational.
- grant_count wraps from 0xFFFF_FFFF to 0.
- Reset mid-BUSY: grant drops immediately (async). After reset, the first edge with req high re-arbitrates from IDLE.

Decomposition:
- Shared package (structs.svh): alu_req_t and alu_ans_t (already present), plus a new alu_arb_state_t enum {IDLE, BUSY}.
- Issue-id age compare belongs as a function in the package, so the SIC units and ROB-side logic use the same rule.
- One sub-module: alu_age_picker. It is a combinational oldest-first tree over req/req_issue_id and outputs winner index and any_valid. It is parameterised by NUM_SIC and ID_WIDTH.

Test Plan:
1. Single requester: req[2]=1, id=5 from cycle 0 -> grant=4'b0100 at cycle 1, owner_idx=2. alu_req equals sic_alu_req[2] (op=ADD, a=3, b=4). grant_count=1.
2. Age order with bubble: SIC0 id=10 and SIC3 id=7 request together -> grant[3] first. release_lock[3] pulse at cycle 4 -> grant=0 at cycle 5, grant[0]=1 at cycle 6, grant_count=2.
3. Wrap-around (ID_WIDTH=8): SIC1 id=250, SIC2 id=3 -> SIC1 granted. After release, SIC2 is granted.
4. Tie and no preemption: SIC1 and SIC2 both id=20 -> SIC1 granted. While BUSY, SIC0 requests with id=15 -> grant stays on SIC1 until release. SIC0 then wins over SIC2.
5. Abandon and spurious release: owner SIC0 drops req without a release pulse -> grant=0 at the next edge. A release_lock[1] pulse while SIC0 owns -> grant unchanged.
6. Reset mid-operation: assert rst_n=0 while grant[3]=1 -> grant, owner_valid, alu_req and grant_count all read 0 before the next clk edge. Deassert with req[1]=1 -> grant[1]=1 one cycle later.

Source files
------------

// File: rtl/alu_lock_arbiter_pkg.sv
// Shared ALU arbitration types, and the wrap-aware issue_id age rule
// used by the SIC units, the ROB side and the lock arbiter.
package alu_lock_arbiter_pkg;

    localparam int unsigned ALU_DATA_W = 16;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SHL,
        ALU_SHR,
        ALU_NOP
    } alu_op_t;

    typedef struct packed {
        alu_op_t               op;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
    } alu_req_t;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic                  zero;
        logic                  carry;
    } alu_ans_t;

    typedef enum logic {
        IDLE,
        BUSY
    } alu_arb_state_t;

    // a is older than b when (a - b) mod 2^id_width has its MSB set (id_width <= 32)
    function automatic logic issue_id_older(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned id_width);
        logic [31:0] diff;
        diff = a - b;
        return diff[5'(id_width - 1)];
    endfunction

endpackage

// File: rtl/alu_age_picker.sv
// Combinational oldest-first selection over the requesting SIC units;
// equal issue_ids resolve to the lowest index.
module alu_age_picker
    import alu_lock_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SIC  = 4,
    parameter int unsigned ID_WIDTH = 8
) (
    input  logic [NUM_SIC-1:0]          req,
    input  logic [NUM_SIC*ID_WIDTH-1:0] req_issue_id,
    output logic [$clog2(NUM_SIC)-1:0]  winner,
    output logic                        any_valid
);

    localparam int unsigned IDX_W = $clog2(NUM_SIC);

    logic [ID_WIDTH-1:0] best_id;
    logic                found;

    // Strict "older" keeps the earlier (lower) index on ties
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        best_id = '0;
        for (int i = 0; i < NUM_SIC; i++) begin
            if (req[i] && (!found ||
                issue_id_older(32'(req_issue_id[i*ID_WIDTH +: ID_WIDTH]), 32'(best_id), ID_WIDTH))) begin
                found   = 1'b1;
                winner  = IDX_W'(i);
                best_id = req_issue_id[i*ID_WIDTH +: ID_WIDTH];
            end
        end
        any_valid = found;
    end

endmodule

// File: rtl/alu_lock_arbiter.sv
// Grants the shared ALU lock to the oldest requesting SIC unit and muxes the
// owner's operation onto the ALU port until the owner releases or abandons it.
module alu_lock_arbiter
    import alu_lock_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SIC  = 4,
    parameter int unsigned ID_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SIC-1:0]            req,
    input  logic [NUM_SIC*ID_WIDTH-1:0]   req_issue_id,
    input  logic [NUM_SIC-1:0]            release_lock,
    input  alu_req_t [NUM_SIC-1:0]        sic_alu_req,
    output logic [NUM_SIC-1:0]            grant,
    output alu_req_t                      alu_req,
    output logic                          owner_valid,
    output logic [$clog2(NUM_SIC)-1:0]    owner_idx,
    output logic [31:0]                   grant_count
);

    localparam int unsigned IDX_W = $clog2(NUM_SIC);

    alu_arb_state_t     state_q;
    alu_arb_state_t     state_d;
    logic [NUM_SIC-1:0] grant_d;
    logic [IDX_W-1:0]   owner_idx_d;
    logic [31:0]        grant_count_d;
    logic [IDX_W-1:0]   winner;
    logic               any_valid;
    logic               owner_done;

    alu_age_picker #(
        .NUM_SIC  (NUM_SIC),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .req          (req),
        .req_issue_id (req_issue_id),
        .winner       (winner),
        .any_valid    (any_valid)
    );

    // Release wins over a still-asserted request from the owner
    assign owner_done  = release_lock[owner_idx] || !req[owner_idx];
    assign owner_valid = (state_q == BUSY);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant       <= '0;
            owner_idx   <= '0;
            grant_count <= '0;
        end else begin
            state_q     <= state_d;
            grant       <= grant_d;
            owner_idx   <= owner_idx_d;
            grant_count <= grant_count_d;
        end
    end

    // Next state: BUSY always returns through IDLE, giving the one-cycle bubble
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid)  state_d = BUSY;
            BUSY:    if (owner_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values for the next edge, plus the combinational ALU mux
    always_comb begin
        grant_d       = grant;
        owner_idx_d   = owner_idx;
        grant_count_d = grant_count;
        alu_req       = '0;
        if (state_q == IDLE && any_valid) begin
            grant_d       = NUM_SIC'(1) << winner;
            owner_idx_d   = winner;
            grant_count_d = grant_count + 32'd1;
        end else if (state_q == BUSY && owner_done) begin
            grant_d = '0;
        end
        if (owner_valid) begin
            alu_req = sic_alu_req[owner_idx];
        end
    end

endmodule

// File: tb/tb_alu_lock_arbiter.sv
// Self-checking bench for alu_lock_arbiter: directed scenarios followed by
// randomized traffic, compared against an oldest-first lock model.
module tb_alu_lock_arbiter;
    import alu_lock_arbiter_pkg::*;

    localparam int unsigned NUM_SIC = 4;
    localparam int unsigned ID_W    = 8;
    localparam int unsigned IDX_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_SIC-1:0]       req;
    logic [NUM_SIC*ID_W-1:0]  req_issue_id;
    logic [NUM_SIC-1:0]       release_lock;
    alu_req_t [NUM_SIC-1:0]   sic_alu_req;
    logic [NUM_SIC-1:0]       grant;
    alu_req_t                 alu_req;
    logic                     owner_valid;
    logic [IDX_W-1:0]         owner_idx;
    logic [31:0]              grant_count;

    alu_lock_arbiter #(
        .NUM_SIC  (NUM_SIC),
        .ID_WIDTH (ID_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_issue_id (req_issue_id),
        .release_lock (release_lock),
        .sic_alu_req  (sic_alu_req),
        .grant        (grant),
        .alu_req      (alu_req),
        .owner_valid  (owner_valid),
        .owner_idx    (owner_idx),
        .grant_count  (grant_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who holds the lock and how many grants were issued
    bit          m_valid = 1'b0;
    int          m_idx   = 0;
    int unsigned m_count = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int id_of(input int i);
        logic [ID_W-1:0] v;
        v = req_issue_id[i*ID_W +: ID_W];
        return int'(v);
    endfunction

    // Oldest requester: nobody strictly older, and no equal id at a lower index
    function automatic int m_pick();
        int  mask;
        bit  ok;
        mask = (1 << ID_W) - 1;
        for (int i = 0; i < NUM_SIC; i++) begin
            if (req[i]) begin
                ok = 1'b1;
                for (int j = 0; j < NUM_SIC; j++) begin
                    if (j != i && req[j]) begin
                        if (((id_of(j) - id_of(i)) & mask) > mask / 2) ok = 1'b0;
                        else if (id_of(j) == id_of(i) && j < i) ok = 1'b0;
                    end
                end
                if (ok) return i;
            end
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        if (!m_valid) begin
            w = m_pick();
            if (w >= 0) begin
                m_valid = 1'b1;
                m_idx   = w;
                m_count = m_count + 1;
            end
        end else if (release_lock[m_idx] || !req[m_idx]) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_count = 0;
    endtask

    task automatic check_outputs();
        alu_req_t exp_alu;
        exp_alu = '0;
        if (m_valid) exp_alu = sic_alu_req[m_idx];
        check("grant", 64'(grant), m_valid ? 64'(1) << m_idx : 64'(0));
        check("owner_valid", 64'(owner_valid), 64'(m_valid));
        check("owner_idx", 64'(owner_idx), 64'(m_idx));
        check("grant_count", 64'(grant_count), 64'(m_count));
        check("alu_req", 64'(alu_req), 64'(exp_alu));
    endtask

    // One clock: model samples the same inputs as the DUT, outputs checked 1 later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        release_lock = '0;
    endtask

    task automatic set_id(input int i, input logic [ID_W-1:0] v);
        req_issue_id[i*ID_W +: ID_W] = v;
    endtask

    alu_req_t    t1_op;
    logic [7:0]  base;
    int          held [NUM_SIC];

    initial begin
        rst_n        = 1'b0;
        req          = '0;
        req_issue_id = '0;
        release_lock = '0;
        sic_alu_req  = '0;
        #3;
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_owner_valid", 64'(owner_valid), 64'(0));
        check("rst_count", 64'(grant_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single requester
        t1_op = '{op: ALU_ADD, a: 16'd3, b: 16'd4};
        sic_alu_req[2] = t1_op;
        set_id(2, 8'd5);
        req = 4'b0100;
        step();
        check("t1_grant", 64'(grant), 64'(4'b0100));
        check("t1_alu", 64'(alu_req), 64'(t1_op));
        check("t1_count", 64'(grant_count), 64'(1));
        req = '0;
        step();
        step();

        // Age order with bubble
        set_id(0, 8'd10);
        set_id(3, 8'd7);
        req = 4'b1001;
        step();
        check("t2_first", 64'(grant), 64'(4'b1000));
        step();
        release_lock = 4'b1000;
        req[3] = 1'b0;
        step();
        check("t2_bubble", 64'(grant), 64'(0));
        step();
        check("t2_second", 64'(grant), 64'(4'b0001));
        req = '0;
        step();
        step();

        // Wrap-around age compare
        set_id(1, 8'd250);
        set_id(2, 8'd3);
        req = 4'b0110;
        step();
        check("t3_wrap_first", 64'(grant), 64'(4'b0010));
        release_lock = 4'b0010;
        req[1] = 1'b0;
        step();
        step();
        check("t3_wrap_second", 64'(grant), 64'(4'b0100));
        req = '0;
        step();
        step();

        // Tie and no preemption
        set_id(1, 8'd20);
        set_id(2, 8'd20);
        req = 4'b0110;
        step();
        check("t4_tie", 64'(grant), 64'(4'b0010));
        set_id(0, 8'd15);
        req[0] = 1'b1;
        step();
        step();
        check("t4_no_preempt", 64'(grant), 64'(4'b0010));
        release_lock = 4'b0010;
        req[1] = 1'b0;
        step();
        step();
        check("t4_older_next", 64'(grant), 64'(4'b0001));
        req = '0;
        step();
        step();

        // Abandon, spurious release, and release racing a held request
        set_id(0, 8'd30);
        req = 4'b0001;
        step();
        release_lock = 4'b0010;
        step();
        check("t5_spurious", 64'(grant), 64'(4'b0001));
        release_lock = 4'b0001;
        step();
        check("t5_release_wins", 64'(grant), 64'(0));
        step();
        check("t5_regrant", 64'(grant), 64'(4'b0001));
        req = '0;
        step();
        check("t5_abandon", 64'(grant), 64'(0));
        release_lock = 4'b1111;
        step();
        step();

        // Asynchronous reset while BUSY
        set_id(3, 8'd40);
        req = 4'b1000;
        step();
        check("t6_pre", 64'(grant), 64'(4'b1000));
        rst_n = 1'b0;
        #1;
        check("t6_grant", 64'(grant), 64'(0));
        check("t6_owner_valid", 64'(owner_valid), 64'(0));
        check("t6_alu", 64'(alu_req), 64'(0));
        check("t6_count", 64'(grant_count), 64'(0));
        model_reset();
        set_id(1, 8'd41);
        req = 4'b0010;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t6_after", 64'(grant), 64'(4'b0010));
        req = '0;
        step();
        step();

        // Randomized traffic; live ids kept within a window under 128
        base = 8'($urandom);
        for (int i = 0; i < NUM_SIC; i++) held[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 1) == 1) base = base + 8'd1;
            for (int i = 0; i < NUM_SIC; i++) begin
                if (req[i]) begin
                    held[i]++;
                    if (held[i] > 40 || $urandom_range(0, 9) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i]  = 1'b1;
                    held[i] = 0;
                    set_id(i, base + 8'($urandom_range(0, 60)));
                end
                release_lock[i]   = ($urandom_range(0, 3) == 0);
                sic_alu_req[i].op = alu_op_t'(3'($urandom_range(0, 7)));
                sic_alu_req[i].a  = 16'($urandom);
                sic_alu_req[i].b  = 16'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
